// File: rtl/redmule_z_store_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : redmule_z_store_ctrl_if
// Brief    : Z-store data path bundle. It carries the row stream from the
//            Z buffer and the beat stream to the Z sink.
// Revision : 1.0 - initial release
// ============================================================================
interface redmule_z_store_ctrl_if #(
    parameter int DATA_W = 320,
    parameter int MEM_DW = 32,
    parameter int STRB   = DATA_W / 8
);
    // Upstream: Z buffer rows (payload only, no non-payload bits)
    logic [DATA_W-MEM_DW-1:0] z_buf_data;
    logic                     z_buf_valid;
    logic                     z_buf_ready;

    // Downstream: registered beats to the sink
    logic [DATA_W-1:0]        z_data;
    logic [STRB-1:0]          z_strb;
    logic                     z_valid;
    logic                     z_ready;

    // The store controller side
    modport master (
        input  z_buf_data, z_buf_valid, z_ready,
        output z_buf_ready, z_data, z_strb, z_valid
    );

    // The environment side: buffer producer plus sink consumer
    modport slave (
        output z_buf_data, z_buf_valid, z_ready,
        input  z_buf_ready, z_data, z_strb, z_valid
    );
endinterface
`default_nettype wire

// File: rtl/redmule_z_store_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : redmule_z_store_ctrl
// Brief    : Store-side sequencer. It pops Z rows, walks the output tiles in
//            this order: rows, then column tiles, then row tiles. It masks the
//            column leftovers and issues one registered beat per row. It also
//            reports stored, tile-done and finished events.
// Revision : 1.0 - initial release
// ============================================================================
module redmule_z_store_ctrl #(
    parameter int DATA_W      = 320,
    parameter int MEM_DW      = 32,
    parameter int BITW        = 16,
    parameter int ARRAY_WIDTH = 12,
    parameter int TOT_DEPTH   = (DATA_W - MEM_DW) / BITW,
    parameter int STRB        = DATA_W / 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          clear_i,
    input  logic                          start_i,
    input  logic [15:0]                   n_row_tiles_i,
    input  logic [15:0]                   n_col_tiles_i,
    input  logic [$clog2(ARRAY_WIDTH):0]  rows_lftovr_i,
    input  logic [$clog2(TOT_DEPTH):0]    cols_lftovr_i,
    redmule_z_store_ctrl_if.master        zif,
    output logic                          stored_o,
    output logic                          tile_done_o,
    output logic                          finished_o,
    output logic                          busy_o
);

    localparam int c_PAY_W = DATA_W - MEM_DW;
    localparam int c_ROW_W = $clog2(ARRAY_WIDTH) + 1;
    localparam int c_COL_W = $clog2(TOT_DEPTH) + 1;
    localparam int c_BPE   = BITW / 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STORE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    // Job configuration, captured when a start is accepted
    logic [15:0]          r_n_row_tiles;
    logic [15:0]          r_n_col_tiles;
    logic [c_ROW_W-1:0]   r_rows_lftovr;
    logic [c_COL_W-1:0]   r_cols_lftovr;

    // Tile walk position of the next row to accept
    logic [15:0]          r_row_cnt;
    logic [15:0]          r_ctile_cnt;
    logic [15:0]          r_rtile_cnt;

    // Output beat register
    logic                 r_valid;
    logic [DATA_W-1:0]    r_data;
    logic [STRB-1:0]      r_strb;
    logic                 r_last_tile;

    logic                 w_busy;
    logic                 w_finished;
    logic                 w_start_acc;
    logic                 w_buf_ready;
    logic                 w_up_acc;
    logic                 w_down_acc;
    logic                 w_last_ctile;
    logic                 w_last_rtile;
    logic                 w_last_row;
    logic                 w_final_row;
    logic [15:0]          w_row_lim;
    logic [c_COL_W-1:0]   w_ncols;
    logic [15:0]          w_nbytes;
    logic [STRB-1:0]      w_strb;
    logic [c_PAY_W-1:0]   w_pay_masked;

    // Handshakes. The output register refills in the same cycle it drains,
    // so a row can be accepted whenever the slot is empty or being popped.
    assign w_buf_ready = (r_state == ST_STORE) && (!r_valid || zif.z_ready);
    assign w_up_acc    = w_buf_ready && zif.z_buf_valid;
    assign w_down_acc  = r_valid && zif.z_ready;

    // Tile geometry of the row currently at the head of the walk
    assign w_last_ctile = (r_ctile_cnt == r_n_col_tiles - 16'd1);
    assign w_last_rtile = (r_rtile_cnt == r_n_row_tiles - 16'd1);
    assign w_row_lim    = (w_last_rtile && (r_rows_lftovr != '0)) ?
                          16'(r_rows_lftovr) : 16'(ARRAY_WIDTH);
    assign w_last_row   = (r_row_cnt == w_row_lim - 16'd1);
    assign w_final_row  = w_last_row && w_last_ctile && w_last_rtile;
    assign w_ncols      = (w_last_ctile && (r_cols_lftovr != '0)) ?
                          r_cols_lftovr : c_COL_W'(TOT_DEPTH);
    assign w_nbytes     = 16'(w_ncols) * 16'(c_BPE);

    // The byte strobe covers the valid elements only. The non-payload bytes
    // above them always stay zero.
    for (genvar g = 0; g < STRB; g++) begin : g_strb
        assign w_strb[g] = (int'(w_nbytes) > g);
    end

    // Elements beyond the column leftover are forced to zero
    for (genvar g = 0; g < TOT_DEPTH; g++) begin : g_mask
        assign w_pay_masked[g*BITW +: BITW] = (int'(w_ncols) > g) ?
                                              zif.z_buf_data[g*BITW +: BITW] : '0;
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and control outputs. A clear overrides every transition
    // and every event.
    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_finished  = 1'b0;
        w_start_acc = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_start_acc = 1'b1;
                    if ((n_row_tiles_i == 16'd0) || (n_col_tiles_i == 16'd0)) begin
                        w_state_nxt = ST_DRAIN;
                    end else begin
                        w_state_nxt = ST_STORE;
                    end
                end
            end
            ST_STORE: begin
                w_busy = 1'b1;
                if (w_up_acc && w_final_row) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_busy = 1'b1;
                if (!r_valid || zif.z_ready) begin
                    w_finished  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (clear_i) begin
            w_state_nxt = ST_IDLE;
            w_finished  = 1'b0;
            w_start_acc = 1'b0;
        end
    end

    // Configuration capture and the tile walk counters
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_n_row_tiles <= '0;
            r_n_col_tiles <= '0;
            r_rows_lftovr <= '0;
            r_cols_lftovr <= '0;
            r_row_cnt     <= '0;
            r_ctile_cnt   <= '0;
            r_rtile_cnt   <= '0;
        end else if (clear_i) begin
            r_row_cnt     <= '0;
            r_ctile_cnt   <= '0;
            r_rtile_cnt   <= '0;
        end else if (w_start_acc) begin
            r_n_row_tiles <= n_row_tiles_i;
            r_n_col_tiles <= n_col_tiles_i;
            r_rows_lftovr <= rows_lftovr_i;
            r_cols_lftovr <= cols_lftovr_i;
            r_row_cnt     <= '0;
            r_ctile_cnt   <= '0;
            r_rtile_cnt   <= '0;
        end else if (w_up_acc) begin
            if (w_last_row) begin
                r_row_cnt <= '0;
                if (w_last_ctile) begin
                    r_ctile_cnt <= '0;
                    r_rtile_cnt <= r_rtile_cnt + 16'd1;
                end else begin
                    r_ctile_cnt <= r_ctile_cnt + 16'd1;
                end
            end else begin
                r_row_cnt <= r_row_cnt + 16'd1;
            end
        end
    end

    // Output beat register. It loads on an upstream accept and empties on a
    // downstream pop. Otherwise it holds, so the beat stays stable under a stall.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid     <= 1'b0;
            r_data      <= '0;
            r_strb      <= '0;
            r_last_tile <= 1'b0;
        end else if (clear_i) begin
            r_valid     <= 1'b0;
        end else if (w_up_acc) begin
            r_valid     <= 1'b1;
            r_data      <= {{MEM_DW{1'b0}}, w_pay_masked};
            r_strb      <= w_strb;
            r_last_tile <= w_last_row;
        end else if (w_down_acc) begin
            r_valid     <= 1'b0;
        end
    end

    assign zif.z_buf_ready = w_buf_ready;
    assign zif.z_valid     = r_valid;
    assign zif.z_data      = r_data;
    assign zif.z_strb      = r_strb;
    assign stored_o        = w_down_acc;
    assign tile_done_o     = w_down_acc && r_last_tile;
    assign finished_o      = w_finished;
    assign busy_o          = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_redmule_z_store_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_redmule_z_store_ctrl
// Brief    : Self-checking bench for the Z store sequencer. It runs a table
//            of jobs with random handshakes against a tile-walk reference
//            model, then applies hand-written clear and reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_redmule_z_store_ctrl;

    localparam int DATA_W = 320;
    localparam int MEM_DW = 32;
    localparam int BITW   = 16;
    localparam int AW     = 12;
    localparam int TD     = 18;
    localparam int STRB   = 40;
    localparam int PAY_W  = DATA_W - MEM_DW;

    typedef struct {
        int nrt;
        int nct;
        int rl;
        int cl;
        int rdy_pct;
        int vld_pct;
        bit spam;
        int exp_beats;
        int exp_tiles;
    } job_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        start = 1'b0;
    logic [15:0] n_rt = '0;
    logic [15:0] n_ct = '0;
    logic [4:0]  rl = '0;
    logic [5:0]  cl = '0;
    logic        stored;
    logic        tile_done;
    logic        finished;
    logic        busy;

    int total = 0;
    int bad   = 0;

    // Reference walk: one entry per expected beat
    int m_ncols[$];
    bit m_tile[$];
    bit m_final[$];

    job_t jobs[10];

    redmule_z_store_ctrl_if #(.DATA_W(DATA_W), .MEM_DW(MEM_DW)) zif ();

    redmule_z_store_ctrl #(
        .DATA_W(DATA_W), .MEM_DW(MEM_DW), .BITW(BITW), .ARRAY_WIDTH(AW)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .clear_i       (clear),
        .start_i       (start),
        .n_row_tiles_i (n_rt),
        .n_col_tiles_i (n_ct),
        .rows_lftovr_i (rl),
        .cols_lftovr_i (cl),
        .zif           (zif.master),
        .stored_o      (stored),
        .tile_done_o   (tile_done),
        .finished_o    (finished),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        total++;
        bad++;
        $display("FAIL %s: %s", name, what);
    endtask

    // Expected beat list: row tiles outermost, column tiles next, rows innermost
    function automatic void build_model(input job_t j);
        int rows;
        int nc;
        m_ncols.delete();
        m_tile.delete();
        m_final.delete();
        for (int rt = 0; rt < j.nrt; rt++) begin
            rows = (rt == j.nrt - 1 && j.rl != 0) ? j.rl : AW;
            for (int ct = 0; ct < j.nct; ct++) begin
                nc = (ct == j.nct - 1 && j.cl != 0) ? j.cl : TD;
                for (int r = 0; r < rows; r++) begin
                    m_ncols.push_back(nc);
                    m_tile.push_back(r == rows - 1);
                    m_final.push_back(rt == j.nrt - 1 && ct == j.nct - 1 && r == rows - 1);
                end
            end
        end
    endfunction

    function automatic logic [319:0] exp_data(input logic [PAY_W-1:0] p, input int nc);
        logic [319:0] d = '0;
        for (int e = 0; e < nc; e++) d[e*BITW +: BITW] = p[e*BITW +: BITW];
        return d;
    endfunction

    function automatic logic [STRB-1:0] exp_strb(input int nc);
        logic [STRB-1:0] s = '0;
        for (int b = 0; b < nc * (BITW / 8); b++) s[b] = 1'b1;
        return s;
    endfunction

    function automatic logic [PAY_W-1:0] rand_pay();
        logic [PAY_W-1:0] p;
        for (int i = 0; i < PAY_W / 32; i++) p[i*32 +: 32] = $urandom();
        return p;
    endfunction

    task automatic run_job(input job_t j);
        logic [PAY_W-1:0] pq[$];
        logic [PAY_W-1:0] exp_p;
        logic [319:0]     prev_data = '0;
        logic [STRB-1:0]  prev_strb = '0;
        int  c = 0, beats = 0, tiles = 0, fins = 0, acc = 0;
        int  first_c = -1, last_c = -1, fin_c = -1;
        bit  prev_stall = 0, prev_up = 0, prev_fin = 0, prev_busy = 0;
        bit  done = 0, down, exp_rdy;
        build_model(j);
        while (!done) begin
            @(posedge clk); #1;
            if (c == 0) begin
                n_rt  = 16'(j.nrt);
                n_ct  = 16'(j.nct);
                rl    = 5'(j.rl);
                cl    = 6'(j.cl);
                start = 1'b1;
            end else begin
                // configuration must already be latched, so scramble it
                start = j.spam && prev_busy && !prev_fin;
                n_rt  = 16'($urandom());
                n_ct  = 16'($urandom());
                rl    = 5'($urandom());
                cl    = 6'($urandom());
            end
            zif.z_ready     = ($urandom_range(99) < j.rdy_pct);
            zif.z_buf_valid = ($urandom_range(99) < j.vld_pct);
            zif.z_buf_data  = rand_pay();
            #1;
            if (c == 1) chk("busy_after_start", busy, 1'b1);
            if (prev_up) chk("valid_latency", zif.z_valid, 1'b1);
            if (prev_stall) begin
                chk("stall_valid", zif.z_valid, 1'b1);
                chk("stall_data", zif.z_data, prev_data);
                chk("stall_strb", zif.z_strb, prev_strb);
            end
            exp_rdy = (c >= 1) && (acc < j.exp_beats) && (!zif.z_valid || zif.z_ready);
            chk("buf_ready", zif.z_buf_ready, exp_rdy);
            if (zif.z_buf_valid && zif.z_buf_ready) begin
                pq.push_back(zif.z_buf_data);
                acc++;
            end
            down = zif.z_valid && zif.z_ready;
            chk("stored", stored, down);
            if (down) begin
                if (beats >= m_ncols.size() || pq.size() == 0) begin
                    fail_now("extra_beat", "got an unexpected beat, required none");
                end else begin
                    exp_p = pq.pop_front();
                    chk("beat_data", zif.z_data, exp_data(exp_p, m_ncols[beats]));
                    chk("beat_strb", zif.z_strb, exp_strb(m_ncols[beats]));
                    chk("beat_tile_done", tile_done, m_tile[beats]);
                    chk("beat_finished", finished, m_final[beats]);
                end
                if (first_c < 0) first_c = c;
                last_c = c;
                beats++;
            end else begin
                chk("idle_tile_done", tile_done, 1'b0);
                chk("idle_finished", finished, (j.exp_beats == 0 && c == 1));
            end
            if (tile_done) tiles++;
            if (finished) begin
                fins++;
                fin_c = c;
            end
            if (prev_fin) begin
                chk("busy_fall", busy, 1'b0);
                done = 1;
            end
            prev_fin   = finished;
            prev_busy  = busy;
            prev_stall = zif.z_valid && !zif.z_ready;
            prev_data  = zif.z_data;
            prev_strb  = zif.z_strb;
            prev_up    = zif.z_buf_valid && zif.z_buf_ready;
            c++;
            if (c > 4000 && !done) begin
                fail_now("timeout", "got no job end, required finished within 4000 cycles");
                done = 1;
            end
        end
        start = 1'b0;
        chk("job_beats", beats, j.exp_beats);
        chk("job_tiles", tiles, j.exp_tiles);
        chk("job_finished_count", fins, 1);
        chk("job_leftover_rows", pq.size(), 0);
        if (j.exp_beats == 0) begin
            chk("empty_finish_cycle", fin_c, 1);
        end else begin
            chk("finish_on_last_beat", fin_c, last_c);
        end
        if (j.rdy_pct == 100 && j.vld_pct == 100 && j.exp_beats > 0) begin
            chk("first_beat_cycle", first_c, 2);
            chk("beats_back_to_back", last_c - first_c, j.exp_beats - 1);
        end
    endtask

    initial begin
        int st;
        bit hit;
        zif.z_buf_valid = 1'b0;
        zif.z_buf_data  = '0;
        zif.z_ready     = 1'b0;

        //             nrt nct rl  cl  rdy  vld  spam beats tiles
        jobs[0] = '{1,  1,  0,  0,  100, 100, 0,   12,   1};
        jobs[1] = '{1,  2,  0,  5,  100, 100, 0,   24,   2};
        jobs[2] = '{2,  2,  3,  0,  100, 100, 0,   30,   4};
        jobs[3] = '{2,  2,  3,  0,  50,  50,  0,   30,   4};
        jobs[4] = '{1,  0,  0,  0,  100, 100, 0,   0,    0};
        jobs[5] = '{0,  3,  0,  0,  50,  50,  0,   0,    0};
        jobs[6] = '{3,  2,  7,  11, 60,  70,  0,   62,   6};
        jobs[7] = '{1,  1,  1,  1,  100, 100, 1,   1,    1};
        jobs[8] = '{1,  1,  0,  0,  100, 100, 1,   12,   1};
        jobs[9] = '{2,  3,  12, 18, 80,  90,  0,   72,   6};

        // Reset state
        #12;
        chk("rst_z_valid", zif.z_valid, 1'b0);
        chk("rst_z_data", zif.z_data, '0);
        chk("rst_z_strb", zif.z_strb, '0);
        chk("rst_buf_ready", zif.z_buf_ready, 1'b0);
        chk("rst_stored", stored, 1'b0);
        chk("rst_tile_done", tile_done, 1'b0);
        chk("rst_finished", finished, 1'b0);
        chk("rst_busy", busy, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 10; i++) run_job(jobs[i]);

        // Clear while the seventh beat is stalled at the sink
        @(posedge clk); #1;
        n_rt = 16'd1; n_ct = 16'd1; rl = '0; cl = '0;
        start = 1'b1;
        zif.z_buf_valid = 1'b1;
        zif.z_ready = 1'b1;
        st = 0;
        hit = 0;
        for (int k = 0; k < 40 && !hit; k++) begin
            @(posedge clk); #1;
            if (k > 0) start = 1'b0;
            zif.z_buf_data = rand_pay();
            zif.z_ready = (st < 6);
            #1;
            if (stored) st++;
            if (zif.z_valid && !zif.z_ready && st == 6) hit = 1;
        end
        if (!hit) fail_now("clear_setup", "got no stalled seventh beat, required one");
        @(posedge clk); #1;
        clear = 1'b1;
        #1;
        chk("clear_cycle_finished", finished, 1'b0);
        @(posedge clk); #1;
        clear = 1'b0;
        zif.z_buf_valid = 1'b0;
        #1;
        chk("post_clear_busy", busy, 1'b0);
        chk("post_clear_valid", zif.z_valid, 1'b0);
        chk("post_clear_buf_ready", zif.z_buf_ready, 1'b0);
        chk("post_clear_finished", finished, 1'b0);
        @(posedge clk); #1; #1;
        chk("post_clear_finished_2", finished, 1'b0);

        // A fresh job after the clear runs to completion
        run_job(jobs[0]);

        // A second random-handshake pass over the multi-tile job
        run_job(jobs[3]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
